// File: rtl/bus_share_arbiter.sv
// bus_share_arbiter: round-robin owner selection plus GRANT/STROBE/HOLD/TURN sequencing of the
// shared data bus. Defining BUS_ARB_BURST_EN lets one grant carry up to BURST_LEN words.
module bus_share_arbiter #(
   parameter int N         = 4,
   parameter int BURST_LEN = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] link_bus,
   output logic         write,
   output logic [N-1:0] ack,
   output logic         busy,
   output logic [15:0]  xfer_cnt
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
`ifdef BUS_ARB_BURST_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif
   localparam int          WORDS_PER_GRANT = BURST_EN ? BURST_LEN : 1;
   localparam logic [3:0]  LAST_IDX        = 4'(WORDS_PER_GRANT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_STROBE,
      S_HOLD,
      S_TURN
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [N-1:0]  req_q, req_d;
   logic [3:0]    burst_idx_q, burst_idx_d;
   logic [N-1:0]  link_bus_q, link_bus_d;
   logic          write_q, write_d;
   logic [N-1:0]  ack_q, ack_d;
   logic          busy_q, busy_d;
   logic [15:0]   xfer_cnt_q, xfer_cnt_d;

   logic [IW-1:0] cand;
   logic [IW-1:0] win_idx;
   logic          win_found;
   logic [N-1:0]  owner_oh;

   // First set request searching upward from the last owner, wrapping modulo N.
   always_comb begin
      cand      = ptr_q;
      win_idx   = ptr_q;
      win_found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(ptr_q) + k) % N);
         if (!win_found && req_q[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      req_d       = req;
      burst_idx_d = burst_idx_q;
      xfer_cnt_d  = xfer_cnt_q;
      case (state_q)
         S_IDLE, S_TURN: begin
            if (win_found) begin
               state_d     = S_GRANT;
               ptr_d       = win_idx;
               burst_idx_d = 4'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT:  state_d = S_STROBE;
         S_STROBE: state_d = S_HOLD;
         S_HOLD: begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
            // Without bursting LAST_IDX is 0, so this never continues.
            if (req_q[ptr_q] && (burst_idx_q != LAST_IDX)) begin
               state_d     = S_GRANT;
               burst_idx_d = burst_idx_q + 4'd1;
            end else begin
               state_d = S_TURN;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are computed from the next state so they register in step with it.
      owner_oh        = '0;
      owner_oh[ptr_d] = 1'b1;
      link_bus_d = ((state_d == S_GRANT) || (state_d == S_STROBE) || (state_d == S_HOLD)) ?
                   owner_oh : '0;
      write_d    = (state_d == S_STROBE);
      ack_d      = (state_d == S_HOLD) ? owner_oh : '0;
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= IW'(N - 1);
         req_q       <= '0;
         burst_idx_q <= 4'd0;
         link_bus_q  <= '0;
         write_q     <= 1'b0;
         ack_q       <= '0;
         busy_q      <= 1'b0;
         xfer_cnt_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         req_q       <= req_d;
         burst_idx_q <= burst_idx_d;
         link_bus_q  <= link_bus_d;
         write_q     <= write_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
         xfer_cnt_q  <= xfer_cnt_d;
      end
   end

   assign link_bus = link_bus_q;
   assign write    = write_q;
   assign ack      = ack_q;
   assign busy     = busy_q;
   assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Bench for bus_share_arbiter: vector table, directed corner sequences, and random requests
// compared each cycle against a word-level model of the bus schedule.
module tb_bus_share_arbiter;

   localparam int N         = 4;
   localparam int BURST_LEN = 4;
`ifdef BUS_ARB_BURST_EN
   localparam int WORDS_MAX = BURST_LEN;
`else
   localparam int WORDS_MAX = 1;
`endif

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] link_bus;
   logic         write;
   logic [N-1:0] ack;
   logic         busy;
   logic [15:0]  xfer_cnt;

   int total = 0;
   int bad   = 0;

   bus_share_arbiter #(.N(N), .BURST_LEN(BURST_LEN)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .link_bus (link_bus),
      .write    (write),
      .ack      (ack),
      .busy     (busy),
      .xfer_cnt (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit has_bit(input logic [N-1:0] v, input int i);
      return ((int'(v) >> i) & 1) == 1;
   endfunction

   function automatic int oh2i(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (has_bit(v, i)) return i;
      return -1;
   endfunction

   function automatic int pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) if (has_bit(r, (last + k) % N)) return (last + k) % N;
      return last;
   endfunction

   // ---------------- reference model ----------------
   // m_pos: 0 idle, 1..3 = setup/strobe/capture slot of a word, 4 = undriven gap.
   // Requests are acted on one cycle after they are presented.
   int           m_pos;
   int           m_owner;
   int           m_words;
   logic [N-1:0] m_seen;
   logic [15:0]  m_cnt;

   task automatic model_reset();
      m_pos   = 0;
      m_owner = N - 1;
      m_words = 0;
      m_seen  = '0;
      m_cnt   = 16'd0;
   endtask

   task automatic model_edge(input logic [N-1:0] req_now);
      logic [N-1:0] r;
      r      = m_seen;
      m_seen = req_now;
      if (m_pos == 0 || m_pos == 4) begin
         if (r != '0) begin
            m_owner = pick(r, m_owner);
            m_pos   = 1;
            m_words = 1;
         end else begin
            m_pos = 0;
         end
      end else if (m_pos == 3) begin
         m_cnt = m_cnt + 16'd1;
         if (has_bit(r, m_owner) && m_words < WORDS_MAX) begin
            m_pos   = 1;
            m_words = m_words + 1;
         end else begin
            m_pos = 4;
         end
      end else begin
         m_pos = m_pos + 1;
      end
   endtask

   task automatic step();
      logic [N-1:0] r_now;
      logic [N-1:0] e_link;
      logic [N-1:0] e_ack;
      r_now = req;
      @(posedge clk);
      #1;
      model_edge(r_now);
      e_link = (m_pos >= 1 && m_pos <= 3) ? N'(1 << m_owner) : '0;
      e_ack  = (m_pos == 3) ? N'(1 << m_owner) : '0;
      chk("mdl_link", 32'(link_bus), 32'(e_link));
      chk("mdl_write", 32'(write), 32'(m_pos == 2));
      chk("mdl_ack", 32'(ack), 32'(e_ack));
      chk("mdl_busy", 32'(busy), 32'(m_pos != 0));
      chk("mdl_cnt", 32'(xfer_cnt), 32'(m_cnt));
      chk("inv_link_onehot0", 32'($onehot0(link_bus)), 32'd1);
      chk("inv_write_owned", 32'(!write || $onehot(link_bus)), 32'd1);
   endtask

   // Asynchronous reset pulse placed mid-cycle; outputs must clear without a clock edge.
   task automatic apply_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_link", 32'(link_bus), 32'd0);
      chk("rst_write", 32'(write), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(xfer_cnt), 32'd0);
      #2 rst_n = 1'b1;
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] link;
      logic         wr;
      logic [N-1:0] ack;
      logic         bsy;
      logic [15:0]  cnt;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int           guard;
      int           acks;
      int           nw;
      int           last_w;
      int           cyc;
      bit           started;
      bit           done;
      int           busy_cyc;
      int           zero_run;
      int           grants[$];
      logic [N-1:0] prev;

      // single word to requester 2, then a word to requester 1 whose request drops in GRANT
      vecs[0]  = '{4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd0};
      vecs[1]  = '{4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b1, 16'd0};
      vecs[2]  = '{4'b0000, 4'b0100, 1'b1, 4'b0000, 1'b1, 16'd0};
      vecs[3]  = '{4'b0000, 4'b0100, 1'b0, 4'b0100, 1'b1, 16'd0};
      vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'd1};
      vecs[5]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd1};
      vecs[6]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd1};
      vecs[7]  = '{4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b1, 16'd1};
      vecs[8]  = '{4'b0000, 4'b0010, 1'b1, 4'b0000, 1'b1, 16'd1};
      vecs[9]  = '{4'b0000, 4'b0010, 1'b0, 4'b0010, 1'b1, 16'd1};
      vecs[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'd2};
      vecs[11] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'd2};

      rst_n = 1'b0;
      req   = '0;
      model_reset();
      @(posedge clk);
      #1;
      chk("init_link", 32'(link_bus), 32'd0);
      chk("init_write", 32'(write), 32'd0);
      chk("init_ack", 32'(ack), 32'd0);
      chk("init_busy", 32'(busy), 32'd0);
      chk("init_cnt", 32'(xfer_cnt), 32'd0);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         req = vecs[i].req;
         step();
         chk($sformatf("vec%0d_link", i), 32'(link_bus), 32'(vecs[i].link));
         chk($sformatf("vec%0d_write", i), 32'(write), 32'(vecs[i].wr));
         chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
         chk($sformatf("vec%0d_cnt", i), 32'(xfer_cnt), 32'(vecs[i].cnt));
      end

      // reset while the strobe is high
      req = '0;
      apply_reset();
      req   = 4'b0001;
      guard = 0;
      while (!write && guard < 10) begin
         step();
         guard++;
      end
      chk("strobe_reached", 32'(write), 32'd1);
      apply_reset();
      step();
      chk("after_rst_edge1_link", 32'(link_bus), 32'd0);
      step();
      chk("after_rst_edge2_link", 32'(link_bus), 32'(4'b0001));

`ifndef BUS_ARB_BURST_EN
      // all requesting: strict rotation with a one-cycle undriven gap
      req = '0;
      apply_reset();
      req      = 4'b1111;
      prev     = '0;
      acks     = 0;
      busy_cyc = 0;
      zero_run = 0;
      guard    = 0;
      grants.delete();
      while (acks < 5 && guard < 60) begin
         step();
         guard++;
         if (busy) busy_cyc++;
         if (link_bus != '0 && prev == '0) begin
            if (grants.size() > 0) chk("rr_gap_len", 32'(zero_run), 32'd1);
            grants.push_back(oh2i(link_bus));
         end
         zero_run = (link_bus == '0) ? zero_run + 1 : 0;
         if (ack != '0) acks++;
         prev = link_bus;
      end
      chk("rr_acks", 32'(acks), 32'd5);
      step();
      if (busy) busy_cyc++;
      chk("rr_cnt", 32'(xfer_cnt), 32'd5);
      chk("rr_busy_cycles", 32'(busy_cyc), 32'd20);
      chk("rr_grant_count", 32'(grants.size()), 32'd5);
      for (int i = 0; i < grants.size(); i++)
         chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % N));
`else
      // burst: four strobes three cycles apart under one continuous grant, then requester 3
      req = '0;
      apply_reset();
      req     = 4'b1001;
      nw      = 0;
      last_w  = -1;
      cyc     = 0;
      started = 1'b0;
      done    = 1'b0;
      guard   = 0;
      while (!done && guard < 60) begin
         step();
         guard++;
         cyc++;
         if (link_bus == 4'b0001) begin
            started = 1'b1;
            if (write) begin
               nw++;
               if (last_w >= 0) chk("burst_spacing", 32'(cyc - last_w), 32'd3);
               last_w = cyc;
            end
         end else if (started) begin
            done = 1'b1;
            chk("burst_turn_link", 32'(link_bus), 32'd0);
         end
      end
      chk("burst_writes", 32'(nw), 32'd4);
      step();
      chk("burst_next_owner", 32'(link_bus), 32'(4'b1000));
`endif

      // counter wrap: preload the count so the wrap is reached in two words
      req = '0;
      apply_reset();
      force dut.xfer_cnt_q = 16'hfffe;
      #1 release dut.xfer_cnt_q;
      m_cnt = 16'hfffe;
      req   = 4'b0001;
      acks  = 0;
      guard = 0;
      while (acks < 2 && guard < 30) begin
         step();
         guard++;
         if (ack != '0) acks++;
      end
      chk("wrap_acks", 32'(acks), 32'd2);
      step();
      chk("wrap_cnt", 32'(xfer_cnt), 32'h0000);

      // random request patterns against the model
      req = '0;
      apply_reset();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_share_arbiter.md
# bus_share_arbiter

Round-robin arbiter and sequencer for the shared 12-bit tri-state data bus. It grants the bus to one of N requesters at a time by asserting that requester's drive enable (its `link_bus`). It then produces the `write` strobe that makes the bus consumer capture the word, inserts a dead cycle between owners, and counts committed words. It sits beside the bus consumer and its requesters; it never touches the data lines itself.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `BURST_LEN`, 4: maximum words per grant when bursting is compiled in (1..16).

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester bus request, level-sensitive.
- `link_bus`  out  N  one-hot drive enables; bit i high means requester i owns and drives `DataBus`.
- `write`  out  1  capture strobe to the bus consumer; the consumer samples on its rising edge.
- `ack`  out  N  one-cycle pulse to the owner: its current word has been captured.
- `busy`  out  1  high whenever the state is not IDLE.
- `xfer_cnt`  out  16  count of committed words, wraps 0xFFFF -> 0x0000.

## Operation
- States: IDLE, GRANT, STROBE, HOLD, TURN. All outputs are registered.
- Arbitration happens in IDLE and TURN:
  - The winner is the first `req` bit set, searching upward from `ptr+1` modulo N.
  - `ptr` then holds the winner's index.
  - On reset, `ptr = N-1`, so requester 0 has first priority.
- IDLE: all outputs low. If any `req` is set, go to GRANT.
- GRANT (setup):
  - `link_bus[w]=1`, `write=0`.
  - The owner's data settles during this cycle.
  - Go to STROBE.
- STROBE:
  - `link_bus[w]=1`, `write=1` for exactly one cycle.
  - Go to HOLD.
- HOLD:
  - `link_bus[w]=1`, `write=0`, `ack[w]=1`.
  - `xfer_cnt` increments on the edge leaving HOLD.
  - Next state is TURN, except for a burst continuation (see Configuration).
- TURN (bus turnaround):
  - `link_bus=0`, `write=0`. Guarantees at least one undriven cycle between any two owners.
  - If any `req` is set, arbitrate and go to GRANT; otherwise go to IDLE.
- Requests are sampled only in IDLE, TURN, and (burst builds only) HOLD.
  - Dropping `req` after GRANT is entered does not abort the word. The word always completes through HOLD.
- Invariants:
  - `link_bus` is zero or one-hot at all times.
  - `write` is high only when `link_bus` is one-hot.

## Timing
- Reset (asynchronous, any state):
  - `link_bus=0`, `write=0`, `ack=0`, `busy=0`, `xfer_cnt=0`.
  - State returns to IDLE and `ptr=N-1`.
  - A partially sequenced word is discarded and not counted.
- Single word from IDLE, with `req` seen at edge 0:
  - GRANT after edge 1.
  - `write` high after edge 2.
  - `ack` after edge 3.
  - TURN after edge 4, IDLE after edge 5 if no request.
- Back-to-back owners: 4 cycles per word (GRANT, STROBE, HOLD, TURN).
- Data stability: `link_bus` rises one full cycle before `write` rises and stays high one full cycle after `write` falls.
- Simultaneous requests: served in round-robin order. With all N requesting continuously, each owner is granted once every N grants.

## Configuration
- Macro: `BUS_ARB_BURST_EN`.
- Defined:
  - In HOLD, if `req[w]` is still high and the burst word index is below `BURST_LEN-1`, go back to GRANT without a TURN, keeping the same owner.
  - The owner updates its data on the edge leaving HOLD.
  - Each burst word takes 3 cycles; the index resets on each new grant.
  - After `BURST_LEN` words, go to TURN regardless of `req`.
- Undefined: exactly one word per grant; HOLD always goes to TURN. `BURST_LEN` is ignored.

## Test plan
- Reset mid-STROBE:
  - Stimulus: `req=4'b0001`, assert `rst_n=0` while `write=1`.
  - Response: all outputs 0 immediately; `xfer_cnt=0`. After release with `req=4'b0001`, `link_bus=4'b0001` two edges later.
- Single word:
  - Stimulus: `req=4'b0100` for one cycle from IDLE.
  - Response: `link_bus=4'b0100` for 3 cycles; `write` high for exactly the middle one; `ack=4'b0100` in the third; `xfer_cnt=1`; then IDLE.
- Round-robin:
  - Stimulus: `req=4'b1111` held, macro undefined.
  - Response: grant order 0,1,2,3,0; every pair of grants separated by one cycle with `link_bus=0`; `xfer_cnt=5` after 20 cycles of activity.
- Late request drop:
  - Stimulus: `req=4'b0010` deasserted during GRANT.
  - Response: the word still completes; `ack[1]` pulses; `xfer_cnt` increments by 1.
- Burst (`BUS_ARB_BURST_EN`, `BURST_LEN=4`):
  - Stimulus: `req=4'b0001` held.
  - Response: 4 `write` pulses 3 cycles apart with `link_bus=4'b0001` continuous, then TURN.
  - If `req[3]` is also set, requester 3 is granted next.
- Counter wrap:
  - Stimulus: force 65536 words.
  - Response: `xfer_cnt` reads 0x0000 after the 65536th `ack`.
